im_fetch_arbiter: RTL and testbench
===================================

Name: im_fetch_arbiter

Overview:
- Shares one single-port, synchronous-read instruction SRAM (1024 x 32) between the CPU fetch stage and a program loader/debug port.
- Replaces the combinational, readmemh-initialised instruction memory for silicon and FPGA builds.
- Sits between PC/IF stage and the SRAM macro. Arbitrates per cycle, translates byte PC to word index, returns read data one cycle after grant, and generates a stall for IF.

Parameters:
- ADDR_W, 10, word-address width (2^ADDR_W words).
- BASE_ADDR, 32'h0000_3000, byte address of word 0 of the text segment.
- STARVE_MAX, 4, consecutive loader-denied cycles before the loader is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- hold  in  1  program-load hold: fetch is never granted while high.
- f_req  in  1  fetch request (level).
- f_pc  in  32  fetch byte address.
- f_gnt  out  1  fetch accepted this cycle (comb).
- f_stall  out  1  f_req & ~f_gnt (comb).
- f_valid  out  1  f_instr valid (registered pulse).
- f_instr  out  32  fetched instruction.
- f_err  out  1  fetch address error, qualified by f_valid.
- l_req  in  1  loader request.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  ADDR_W  loader word index.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader accepted this cycle (comb).
- l_ack  out  1  loader access complete (registered pulse).
- l_rdata  out  32  loader read data, qualified by l_ack.
- m_addr  out  ADDR_W  SRAM word address (comb).
- m_we  out  1  SRAM write enable (comb).
- m_wdata  out  32  SRAM write data.
- m_rdata  in  32  SRAM read data, valid the cycle after the address.

Behaviour:
Reset:
- While reset is low: f_valid = l_ack = 0, f_instr = l_rdata = 0, f_err = 0, wait_cnt = 0, last = IDLE.
- f_gnt, l_gnt and m_we are forced to 0.

Arbitration (comb, each cycle), in priority order:
1. hold: l_gnt = l_req; f_gnt = 0.
2. l_req && wait_cnt == STARVE_MAX: loader wins.
3. f_req: fetch wins.
4. l_req: loader wins.
- At most one grant per cycle.

SRAM drive:
- Fetch wins: m_addr = (f_pc - BASE_ADDR)[ADDR_W+1:2], m_we = 0.
- Loader wins: m_addr = l_addr, m_we = l_we.
- No winner: m_we = 0.
- m_wdata = l_wdata always.

Registered state: last ∈ {IDLE, FETCH, LREAD, LWRITE} records the winner at each edge.
- last == FETCH: f_valid = 1, f_instr = m_rdata (comb passthrough of the registered path).
- last == LREAD: l_ack = 1, l_rdata = m_rdata.
- last == LWRITE: l_ack = 1, l_rdata holds its previous value.

Timing and pipelining:
- Latency is exactly 1 cycle, grant to response.
- Fully pipelined: back-to-back grants to the same requester give back-to-back responses.
- The requester advances its address on the cycle it sees its grant.

wait_cnt:
- Increments (saturating at STARVE_MAX) when l_req && !l_gnt.
- Clears when l_gnt or !l_req.

Boundary cases:
- Write then fetch of the same word on the next cycle returns the new data (SRAM write-first is required of the macro).
- Dropping a req after grant does not cancel the response.
- Fetch is starvable only through hold.
- Reset asserted mid-access: the pending response is discarded and no valid/ack is emitted after release.

Optional Feature:
IM_RANGE_CHECK_EN:
- Defined: f_pc[1:0] != 0, f_pc < BASE_ADDR, or f_pc >= BASE_ADDR + 4*2^ADDR_W raise an error.
  - The access is still granted, but m_addr is not driven from f_pc (m_addr = 0, m_we = 0).
  - The response cycle gives f_valid = 1, f_err = 1, f_instr = 32'h0 (nop).
- Undefined: no check; the index wraps modulo 2^ADDR_W and f_err is tied 0.

Decomposition:
- Package im_arb_pkg holds:
  - state encoding for last (IDLE/FETCH/LREAD/LWRITE);
  - BASE_ADDR default;
  - NOP_INSTR = 32'h0;
  - word-index width helper constant.
- One sub-module is natural: im_arb_pick, the combinational priority/starvation winner select (inputs hold, f_req, l_req, wait_cnt; outputs f_gnt, l_gnt).

Test Plan:
1. Reset release, f_req = 1, f_pc = 0x3000, then 0x3004 on the grant cycle -> f_gnt every cycle; f_valid on consecutive cycles with words 0 and 1.
2. hold = 1, loader writes 0x2402_0005 to index 3 -> l_gnt and m_we on the same cycle, l_ack next cycle. Release hold, fetch 0x300C -> f_instr = 0x2402_0005.
3. Continuous f_req with l_req read of index 7 -> loader denied 4 cycles, granted on the 5th. f_stall = 1 that cycle. l_ack + l_rdata = mem[7] next cycle; wait_cnt = 0.
4. Write index 9 on cycle N, fetch 0x3024 on cycle N+1 -> f_instr = new data.
5. Assert reset low in the cycle after an f_gnt -> no f_valid after release; all outputs 0.
6. With IM_RANGE_CHECK_EN, f_pc = 0x3002 and f_pc = 0x4000 -> f_valid = 1, f_err = 1, f_instr = 0, m_we = 0. Without the macro, 0x4000 returns mem[0].

Source files
------------

// File: rtl/im_fetch_arbiter_pkg.sv
// Shared types and constants for the instruction-memory fetch/loader arbiter.
// No logic of its own.
package im_arb_pkg;

    typedef enum logic [1:0] {
        LAST_IDLE   = 2'd0,
        LAST_FETCH  = 2'd1,
        LAST_LREAD  = 2'd2,
        LAST_LWRITE = 2'd3
    } last_e;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam int          ADDR_W_DEF    = 10;
    // Byte PC to word index shift.
    localparam int          WORD_LSB      = 2;

endpackage

// File: rtl/im_fetch_arbiter_if.sv
// Fetch, loader and SRAM-side signals of the arbiter; slave = arbiter, master = clients plus SRAM.
// Handshake is grant-based: a request is accepted in the cycle its grant is high.
interface im_fetch_arbiter_if #(
    parameter int ADDR_W = 10
) ();
    logic              hold;
    logic              f_req;
    logic [31:0]       f_pc;
    logic              f_gnt;
    logic              f_stall;
    logic              f_valid;
    logic [31:0]       f_instr;
    logic              f_err;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;
    logic              l_ack;
    logic [31:0]       l_rdata;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    modport slave (
        input  hold, f_req, f_pc, l_req, l_we, l_addr, l_wdata, m_rdata,
        output f_gnt, f_stall, f_valid, f_instr, f_err,
               l_gnt, l_ack, l_rdata, m_addr, m_we, m_wdata
    );

    modport master (
        output hold, f_req, f_pc, l_req, l_we, l_addr, l_wdata, m_rdata,
        input  f_gnt, f_stall, f_valid, f_instr, f_err,
               l_gnt, l_ack, l_rdata, m_addr, m_we, m_wdata
    );
endinterface

// File: rtl/im_fetch_arbiter_pick.sv
// Combinational winner select: hold > starved loader > fetch > loader.
// Latency 0; at most one grant per cycle, the loser simply sees no grant.
module im_arb_pick #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             hold_i,
    input  logic             f_req_i,
    input  logic             l_req_i,
    input  logic [CNT_W-1:0] wait_cnt_i,
    output logic             f_gnt_o,
    output logic             l_gnt_o
);

    always_comb begin
        f_gnt_o = 1'b0;
        l_gnt_o = 1'b0;
        if (hold_i) begin
            l_gnt_o = l_req_i;
        end else if (l_req_i && (wait_cnt_i == CNT_W'(STARVE_MAX))) begin
            l_gnt_o = 1'b1;
        end else if (f_req_i) begin
            f_gnt_o = 1'b1;
        end else if (l_req_i) begin
            l_gnt_o = 1'b1;
        end
    end

endmodule

// File: rtl/im_fetch_arbiter.sv
// Shares one sync-read instruction SRAM between IF fetch and loader; IM_RANGE_CHECK_EN flags bad fetch PCs.
// Latency 1 cycle grant to response, fully pipelined; losers stall (f_stall) or wait, loader starves at most STARVE_MAX cycles.
module im_fetch_arbiter
    import im_arb_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter int          STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    im_fetch_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    last_e             last_q, last_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              f_err_q, f_err_d;
    logic [31:0]       l_rdata_q, l_rdata_d;
    logic              pick_f, pick_l;
    logic              f_gnt, l_gnt;
    logic              pc_bad;
    logic [ADDR_W-1:0] f_idx;

    im_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .hold_i     (bus.hold),
        .f_req_i    (bus.f_req),
        .l_req_i    (bus.l_req),
        .wait_cnt_i (wait_cnt_q),
        .f_gnt_o    (pick_f),
        .l_gnt_o    (pick_l)
    );

    // No access may reach the SRAM while reset is asserted.
    assign f_gnt = pick_f & reset;
    assign l_gnt = pick_l & reset;

    assign f_idx = ADDR_W'((bus.f_pc - BASE_ADDR) >> WORD_LSB);

`ifdef IM_RANGE_CHECK_EN
    localparam logic [32:0] PC_END = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_W + WORD_LSB));
    assign pc_bad = (bus.f_pc[1:0] != 2'b00) || (bus.f_pc < BASE_ADDR) ||
                    ({1'b0, bus.f_pc} >= PC_END);
`else
    assign pc_bad = 1'b0;
`endif

    always_comb begin
        bus.m_addr = '0;
        bus.m_we   = 1'b0;
        last_d     = LAST_IDLE;
        f_err_d    = 1'b0;
        wait_cnt_d = '0;
        l_rdata_d  = l_rdata_q;
        if (f_gnt) begin
            last_d  = LAST_FETCH;
            f_err_d = pc_bad;
            if (!pc_bad) begin
                bus.m_addr = f_idx;
            end
        end else if (l_gnt) begin
            last_d     = bus.l_we ? LAST_LWRITE : LAST_LREAD;
            bus.m_addr = bus.l_addr;
            bus.m_we   = bus.l_we;
        end
        if (bus.l_req && !l_gnt) begin
            wait_cnt_d = (wait_cnt_q == CNT_W'(STARVE_MAX)) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        if (last_q == LAST_LREAD) begin
            l_rdata_d = bus.m_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q     <= LAST_IDLE;
            wait_cnt_q <= '0;
            f_err_q    <= 1'b0;
            l_rdata_q  <= '0;
        end else begin
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            f_err_q    <= f_err_d;
            l_rdata_q  <= l_rdata_d;
        end
    end

    assign bus.f_gnt   = f_gnt;
    assign bus.l_gnt   = l_gnt;
    assign bus.f_stall = bus.f_req & ~f_gnt;
    assign bus.m_wdata = bus.l_wdata;
    assign bus.f_valid = (last_q == LAST_FETCH);
    assign bus.f_err   = bus.f_valid & f_err_q;
    assign bus.f_instr = (bus.f_valid && !f_err_q) ? bus.m_rdata : NOP_INSTR;
    assign bus.l_ack   = (last_q == LAST_LREAD) || (last_q == LAST_LWRITE);
    assign bus.l_rdata = (last_q == LAST_LREAD) ? bus.m_rdata : l_rdata_q;

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Directed bench for im_fetch_arbiter with a write-first SRAM model and response scoreboard.
// Expectations follow IM_RANGE_CHECK_EN when it is defined for the build.
module tb_im_fetch_arbiter;
    import im_arb_pkg::*;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] BASE   = 32'h0000_3000;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } fexp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    im_fetch_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    im_fetch_arbiter #(
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] sram   [1024];
    logic [31:0] shadow [1024];
    fexp_t       fq [$];
    logic [31:0] lq [$];
    logic [31:0] last_lrd;
    int          n_chk  = 0;
    int          n_pass = 0;

    // Synchronous-read, write-first SRAM macro model.
    always @(posedge clk) begin
        if (bus.m_we) sram[bus.m_addr] <= bus.m_wdata;
        bus.m_rdata <= bus.m_we ? bus.m_wdata : sram[bus.m_addr];
    end

    function automatic logic [9:0] idx_of(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - BASE;
        return off[11:2];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_resp();
        fexp_t       fe;
        logic [31:0] le;
        chk("f_valid", {31'b0, bus.f_valid}, {31'b0, fq.size() != 0});
        if (fq.size() != 0) begin
            fe = fq.pop_front();
            chk("f_instr", bus.f_instr, fe.dat);
            chk("f_err", {31'b0, bus.f_err}, {31'b0, fe.err});
        end
        chk("l_ack", {31'b0, bus.l_ack}, {31'b0, lq.size() != 0});
        if (lq.size() != 0) begin
            le = lq.pop_front();
            chk("l_rdata", bus.l_rdata, le);
        end
    endtask

    // One cycle: drive, check grants/SRAM drive, push expectations, clock, check responses.
    task automatic cyc(input logic hd, input logic fr, input logic [31:0] pc,
                       input logic lr, input logic lwe, input logic [9:0] la,
                       input logic [31:0] lwd, input logic efg, input logic elg,
                       input logic eerr);
        fexp_t fe;
        bus.hold    = hd;
        bus.f_req   = fr;
        bus.f_pc    = pc;
        bus.l_req   = lr;
        bus.l_we    = lwe;
        bus.l_addr  = la;
        bus.l_wdata = lwd;
        #1;
        chk("f_gnt", {31'b0, bus.f_gnt}, {31'b0, efg});
        chk("l_gnt", {31'b0, bus.l_gnt}, {31'b0, elg});
        chk("f_stall", {31'b0, bus.f_stall}, {31'b0, fr & ~efg});
        chk("m_we", {31'b0, bus.m_we}, {31'b0, elg & lwe});
        if (efg) begin
            chk("m_addr_f", {22'b0, bus.m_addr}, eerr ? 32'h0 : {22'b0, idx_of(pc)});
            fe.dat = eerr ? NOP_INSTR : shadow[idx_of(pc)];
            fe.err = eerr;
            fq.push_back(fe);
        end
        if (elg) begin
            chk("m_addr_l", {22'b0, bus.m_addr}, {22'b0, la});
            if (lwe) begin
                shadow[la] = lwd;
                lq.push_back(last_lrd);
            end else begin
                last_lrd = shadow[la];
                lq.push_back(shadow[la]);
            end
        end
        @(posedge clk);
        #1;
        check_resp();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, BASE, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i]   = 32'hA500_0000 ^ (i * 32'h0001_0011);
            shadow[i] = 32'hA500_0000 ^ (i * 32'h0001_0011);
        end
        last_lrd    = 32'h0;
        bus.hold    = 1'b0;
        bus.f_req   = 1'b1;
        bus.f_pc    = BASE;
        bus.l_req   = 1'b1;
        bus.l_we    = 1'b1;
        bus.l_addr  = 10'd5;
        bus.l_wdata = 32'h1234_5678;
        #3;
        chk("rst_f_gnt", {31'b0, bus.f_gnt}, 32'h0);
        chk("rst_l_gnt", {31'b0, bus.l_gnt}, 32'h0);
        chk("rst_m_we", {31'b0, bus.m_we}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_f_valid", {31'b0, bus.f_valid}, 32'h0);
        chk("rst_l_ack", {31'b0, bus.l_ack}, 32'h0);
        chk("rst_f_instr", bus.f_instr, 32'h0);
        chk("rst_l_rdata", bus.l_rdata, 32'h0);
        chk("rst_f_err", {31'b0, bus.f_err}, 32'h0);
        reset = 1'b1;

        // Back-to-back fetch of words 0 and 1.
        cyc(0, 1, 32'h3000, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 32'h3004, 0, 0, 0, 0, 1, 0, 0);

        // Hold blocks fetch; loader writes index 3, then fetch sees the new word.
        cyc(1, 1, 32'h3008, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h3008, 1, 1, 10'd3, 32'h2402_0005, 0, 1, 0);
        cyc(0, 1, 32'h300C, 0, 0, 0, 0, 1, 0, 0);

        // Loader starved for 4 cycles, forced through on the 5th, then counter restarts.
        cyc(0, 1, 32'h3010, 1, 0, 10'd7, 0, 1, 0, 0);
        cyc(0, 1, 32'h3014, 1, 0, 10'd7, 0, 1, 0, 0);
        cyc(0, 1, 32'h3018, 1, 0, 10'd7, 0, 1, 0, 0);
        cyc(0, 1, 32'h301C, 1, 0, 10'd7, 0, 1, 0, 0);
        cyc(0, 1, 32'h3020, 1, 0, 10'd7, 0, 0, 1, 0);
        cyc(0, 1, 32'h3020, 1, 0, 10'd8, 0, 1, 0, 0);
        cyc(0, 1, 32'h3024, 0, 0, 10'd8, 0, 1, 0, 0);
        cyc(0, 0, 32'h3028, 1, 0, 10'd8, 0, 0, 1, 0);

        // Write index 9 then fetch it next cycle; request dropped after grant.
        cyc(0, 0, 32'h3028, 1, 1, 10'd9, 32'hDEAD_BEEF, 0, 1, 0);
        cyc(0, 1, 32'h3024, 0, 0, 10'd0, 0, 1, 0, 0);
        idle();

`ifdef IM_RANGE_CHECK_EN
        cyc(0, 1, 32'h3002, 0, 0, 0, 0, 1, 0, 1);
        cyc(0, 1, 32'h4000, 0, 0, 0, 0, 1, 0, 1);
        cyc(0, 1, 32'h2FFC, 0, 0, 0, 0, 1, 0, 1);
        cyc(0, 1, 32'h3FFC, 0, 0, 0, 0, 1, 0, 0);
`else
        cyc(0, 1, 32'h4000, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 32'h3FFC, 0, 0, 0, 0, 1, 0, 0);
`endif
        idle();

        // Reset asserted while a fetch grant is pending: response must vanish.
        bus.f_req = 1'b1;
        bus.f_pc  = 32'h3010;
        bus.l_req = 1'b0;
        #1;
        chk("pre_rst_f_gnt", {31'b0, bus.f_gnt}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_f_gnt", {31'b0, bus.f_gnt}, 32'h0);
        chk("mid_rst_m_we", {31'b0, bus.m_we}, 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_f_valid", {31'b0, bus.f_valid}, 32'h0);
        bus.f_req = 1'b0;
        reset     = 1'b1;
        last_lrd  = 32'h0;
        @(posedge clk);
        #1;
        chk("post_rst_f_valid", {31'b0, bus.f_valid}, 32'h0);
        chk("post_rst_l_ack", {31'b0, bus.l_ack}, 32'h0);
        chk("post_rst_f_instr", bus.f_instr, 32'h0);
        chk("post_rst_l_rdata", bus.l_rdata, 32'h0);
        chk("post_rst_f_err", {31'b0, bus.f_err}, 32'h0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
